mem_ctrl: RTL and testbench
===========================

# mem_ctrl

Sequencer between the CPU datapath (MAR/MDR and control unit) and the word-addressed RAM. Turns a level-held read or write request into a clean, glitch-free read or write strobe pulse, since the RAM acts on strobe rising edges. Holds address and write data stable around that pulse, captures read data, and returns a one-cycle completion with an error flag. Reads and writes to out-of-range addresses never reach the RAM.

## Interface
- `ADDR_W`, 8: RAM address width; valid word addresses are 0 .. 2^ADDR_W-1.
- `STROBE_CYC`, 1: cycles the RAM strobe is held high (≥1).
- `clock` in 1: sole clock, rising edge.
- `clear` in 1: reset, asynchronous, active-high.
- `req_rd` in 1: read request from control unit (level).
- `req_wr` in 1: write request from control unit (level).
- `mar` in 32: word address from MAR.
- `mdr_out` in 32: write data from MDR.
- `busy` out 1: a request is in progress (any state other than IDLE).
- `done` out 1: one-cycle completion pulse.
- `err` out 1: valid only with `done`. High for bad address or simultaneous rd/wr.
- `rd_data` out 32: captured read word, feeds MDR input mux.
- `ram_addr` out ADDR_W: to RAM address.
- `ram_din` out 32: to RAM data_in.
- `ram_write` out 1: RAM write strobe.
- `ram_read` out 1: RAM read strobe.
- `ram_dout` in 32: RAM data_out.

## Operation
- All outputs are registered. Reset values are 0 for all outputs; the state register resets to IDLE.
- States:
  - IDLE: sample requests.
  - SETUP: drive `ram_addr`/`ram_din`, both strobes low.
  - STROBE: one strobe high.
  - HOLD: strobes low, address and data held.
  - DONE: pulse `done`.
- IDLE with `req_rd` xor `req_wr` high:
  - latch `mar[ADDR_W-1:0]` and `mdr_out` and the operation type;
  - if `mar[31:ADDR_W]` ≠ 0, set error and go to DONE with no strobe;
  - otherwise go to SETUP.
- IDLE with both requests high: error, go to DONE, no RAM access.
- SETUP → STROBE.
- STROBE: `ram_write` or `ram_read` held high for exactly STROBE_CYC cycles, counted by a down-counter, then → HOLD.
- HOLD: on a read, `rd_data` <= `ram_dout` at the end of the HOLD cycle. Then → DONE.
- DONE:
  - `done`=1 for one cycle, `err` per latched flag;
  - `rd_data` is unchanged on writes and on errors;
  - → IDLE unconditionally.
- Requests are sampled only in IDLE. Changes to `req_*`, `mar` or `mdr_out` while busy are ignored.
- The requester must drop `req_*` in the `done` cycle. A request still high in IDLE is a new request.
- `ram_read` and `ram_write` are never high together and never glitch. Each is a single contiguous pulse per access.

## Timing
- Request sampled high in IDLE at edge N → SETUP at N+1, STROBE at N+2 .. N+1+STROBE_CYC, HOLD at N+2+STROBE_CYC, DONE at N+3+STROBE_CYC.
- With the default STROBE_CYC=1, `done` is high in cycle N+4.
- Error path: `done`/`err` high in cycle N+1 with no strobe.
- `ram_addr`/`ram_din` are stable from SETUP through HOLD. That gives one cycle of setup before the strobe rises and one cycle of hold after it falls.
- Back-to-back: the next request can be sampled in the cycle after DONE, giving a throughput of one access per STROBE_CYC+4 cycles.
- `clear` mid-access:
  - strobes, `busy`, `done` and `err` drop immediately (asynchronous);
  - the access is abandoned with no `done`;
  - a write whose strobe already rose may have completed in RAM.

## Structure
- Shared header `mem_defs.vh` holds:
  - state encodings (IDLE=0, SETUP=1, STROBE=2, HOLD=3, DONE=4, 3-bit);
  - the default ADDR_W;
  - `MEM_WORD_W`=32.
- One natural sub-module, `strobe_timer`: a loadable down-counter sized from STROBE_CYC that reports expiry to the FSM.
- Everything else lives in `mem_ctrl`.

## Test plan
- Write then read:
  - `req_wr`, `mar`=0x10, `mdr_out`=0xDEADBEEF → exactly one `ram_write` pulse with `ram_addr`=0x10 and `done` at N+4, `err`=0;
  - then `req_rd` with `mar`=0x10 → one `ram_read` pulse, `rd_data`=0xDEADBEEF at `done`.
- Bad address: `req_rd`, `mar`=0x100 → `done`=1, `err`=1 at N+1, no strobe, `rd_data` unchanged.
- Conflict: `req_rd`=`req_wr`=1 → `err` at N+1, no strobe.
- STROBE_CYC=3:
  - read at 0xFF (boundary) → `ram_read` high exactly 3 cycles, `done` at N+6;
  - changing `mar` while busy does not alter `ram_addr`.
- Reset mid-access: assert `clear` during STROBE → `ram_write`=0 and `busy`=0 in the same cycle, no `done`. A following read at a fresh address completes normally.
- Held request: keep `req_rd` high past `done` → a second access starts in the next IDLE, and strobes never overlap or glitch.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the RAM access sequencer: state encodings,
// operation type, word width and the default RAM address width.
package mem_ctrl_pkg;

  localparam int MEM_WORD_W = 32;
  localparam int DEF_ADDR_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

  // Bits needed to hold STROBE_CYC-1 (at least one bit).
  function automatic int timer_w(input int cyc);
    return (cyc < 2) ? 1 : $clog2(cyc);
  endfunction

endpackage

// File: rtl/mem_ctrl_strobe_timer.sv
// Loadable down-counter timing the RAM strobe width. Loaded with
// STROBE_CYC-1 while in SETUP, counts during STROBE, expired at zero.
module mem_ctrl_strobe_timer
  import mem_ctrl_pkg::*;
#(
  parameter int STROBE_CYC = 1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  input  logic i_run,
  output logic o_expired
);

  localparam int CW = timer_w(STROBE_CYC);
  localparam logic [CW-1:0] LOAD_VAL = CW'(STROBE_CYC - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= LOAD_VAL;
    end else if (i_run && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/mem_ctrl.sv
// Sequencer between the CPU MAR/MDR and a word-addressed RAM: turns a level
// request into one clean registered strobe pulse with setup and hold cycles.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int STROBE_CYC = 1
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  req_rd,
  input  logic                  req_wr,
  input  logic [MEM_WORD_W-1:0] mar,
  input  logic [MEM_WORD_W-1:0] mdr_out,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [MEM_WORD_W-1:0] rd_data,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic [MEM_WORD_W-1:0] ram_din,
  output logic                  ram_write,
  output logic                  ram_read,
  input  logic [MEM_WORD_W-1:0] ram_dout,
  output logic [2:0]            o_dbg_state
);

  state_t                r_state;
  state_t                w_next_state;
  op_t                   r_op;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_err;
  logic                  r_ram_read;
  logic                  r_ram_write;
  logic [ADDR_W-1:0]     r_ram_addr;
  logic [MEM_WORD_W-1:0] r_ram_din;
  logic [MEM_WORD_W-1:0] r_rd_data;

  logic                  w_addr_ok;
  logic                  w_single;
  logic                  w_accept;
  logic                  w_reject;
  logic                  w_expired;
  logic                  w_busy_nxt;
  logic                  w_done_nxt;
  logic                  w_err_nxt;
  logic                  w_read_nxt;
  logic                  w_write_nxt;

  // Request qualification: only meaningful while idle.
  assign w_addr_ok = ((mar >> ADDR_W) == '0);
  assign w_single  = req_rd ^ req_wr;
  assign w_accept  = (r_state == ST_IDLE) && w_single && w_addr_ok;
  assign w_reject  = (r_state == ST_IDLE) &&
                     ((req_rd && req_wr) || (w_single && !w_addr_ok));

  mem_ctrl_strobe_timer #(
    .STROBE_CYC(STROBE_CYC)
  ) u_strobe_timer (
    .i_clk    (clock),
    .i_rst    (clear),
    .i_load   (r_state == ST_SETUP),
    .i_run    (r_state == ST_STROBE),
    .o_expired(w_expired)
  );

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_reject) begin
          w_next_state = ST_DONE;
        end else if (w_accept) begin
          w_next_state = ST_SETUP;
        end
      end
      ST_SETUP:  w_next_state = ST_STROBE;
      ST_STROBE: if (w_expired) w_next_state = ST_HOLD;
      ST_HOLD:   w_next_state = ST_DONE;
      ST_DONE:   w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so each strobe
  // is a single flop output aligned exactly with the STROBE state.
  always_comb begin
    w_busy_nxt  = (w_next_state != ST_IDLE);
    w_done_nxt  = (w_next_state == ST_DONE);
    w_err_nxt   = (w_next_state == ST_DONE) && (r_state == ST_IDLE);
    w_read_nxt  = (w_next_state == ST_STROBE) && (r_op == OP_RD);
    w_write_nxt = (w_next_state == ST_STROBE) && (r_op == OP_WR);
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_ram_read  <= 1'b0;
      r_ram_write <= 1'b0;
    end else begin
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_err       <= w_err_nxt;
      r_ram_read  <= w_read_nxt;
      r_ram_write <= w_write_nxt;
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_op       <= OP_RD;
      r_ram_addr <= '0;
      r_ram_din  <= '0;
      r_rd_data  <= '0;
    end else begin
      if (w_accept) begin
        r_op       <= req_wr ? OP_WR : OP_RD;
        r_ram_addr <= mar[ADDR_W-1:0];
        r_ram_din  <= mdr_out;
      end
      if ((r_state == ST_HOLD) && (r_op == OP_RD)) begin
        r_rd_data <= ram_dout;
      end
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign err         = r_err;
  assign rd_data     = r_rd_data;
  assign ram_addr    = r_ram_addr;
  assign ram_din     = r_ram_din;
  assign ram_write   = r_ram_write;
  assign ram_read    = r_ram_read;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: two instances (STROBE_CYC=1 and 3) each with a RAM
// model, checked against a memory/latency reference model kept here.
module tb_mem_ctrl;

  logic        clock;
  logic        clear;
  logic        req_rd  [2];
  logic        req_wr  [2];
  logic [31:0] mar     [2];
  logic [31:0] mdr_out [2];
  logic        busy    [2];
  logic        done    [2];
  logic        err     [2];
  logic [31:0] rd_data [2];
  logic [7:0]  ram_addr[2];
  logic [31:0] ram_din [2];
  logic        ram_write[2];
  logic        ram_read [2];
  logic [2:0]  dbg     [2];
  int          rd_pulses[2];
  int          wr_pulses[2];
  int          rd_width [2];
  int          wr_width [2];
  int          overlaps [2];
  logic [7:0]  strobe_addr[2];

  int          total;
  int          bad;
  logic [31:0] exp_q[$];
  logic [31:0] exp_mem[2][256];
  logic [31:0] exp_rd[2];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] init_pat(input int d, input int a);
    return 32'hA5000000 ^ (32'(a) * 32'h01010101) ^ (32'(d) << 20);
  endfunction

  function automatic int cyc_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic        w_busy, w_done, w_err, w_rd, w_wr;
    logic [31:0] w_rd_data, w_din;
    logic [7:0]  w_addr;
    logic [2:0]  w_dbg;
    logic [31:0] dout;
    bit   [31:0] mem [256];
    bit          seen[256];
    int          rd_p, wr_p, rd_w, wr_w, ovl;
    bit          prev_r, prev_w;
    logic [7:0]  s_addr;

    mem_ctrl #(.ADDR_W(8), .STROBE_CYC((g == 0) ? 1 : 3)) u_dut (
      .clock      (clock),
      .clear      (clear),
      .req_rd     (req_rd[g]),
      .req_wr     (req_wr[g]),
      .mar        (mar[g]),
      .mdr_out    (mdr_out[g]),
      .busy       (w_busy),
      .done       (w_done),
      .err        (w_err),
      .rd_data    (w_rd_data),
      .ram_addr   (w_addr),
      .ram_din    (w_din),
      .ram_write  (w_wr),
      .ram_read   (w_rd),
      .ram_dout   (dout),
      .o_dbg_state(w_dbg)
    );

    // RAM model: acts on strobe rising edges.
    always @(posedge w_wr) begin
      mem[w_addr]  = w_din;
      seen[w_addr] = 1'b1;
    end
    always @(posedge w_rd) begin
      dout = seen[w_addr] ? mem[w_addr] : init_pat(g, int'(w_addr));
    end

    // Strobe monitor: pulse counts, widths, overlap, address at rise.
    always @(negedge clock) begin
      if (w_rd && w_wr) ovl++;
      if (w_rd) begin
        if (!prev_r) begin rd_p++; rd_w = 1; s_addr = w_addr; end
        else rd_w++;
      end
      if (w_wr) begin
        if (!prev_w) begin wr_p++; wr_w = 1; s_addr = w_addr; end
        else wr_w++;
      end
      prev_r = w_rd;
      prev_w = w_wr;
    end

    assign busy[g]        = w_busy;
    assign done[g]        = w_done;
    assign err[g]         = w_err;
    assign rd_data[g]     = w_rd_data;
    assign ram_addr[g]    = w_addr;
    assign ram_din[g]     = w_din;
    assign ram_write[g]   = w_wr;
    assign ram_read[g]    = w_rd;
    assign dbg[g]         = w_dbg;
    assign rd_pulses[g]   = rd_p;
    assign wr_pulses[g]   = wr_p;
    assign rd_width[g]    = rd_w;
    assign wr_width[g]    = wr_w;
    assign overlaps[g]    = ovl;
    assign strobe_addr[g] = s_addr;
  end

  // One access through instance d; the reference model predicts latency,
  // error, strobe counts/width and the rd_data seen at done.
  task automatic do_access(input int d, input bit rd, input bit wr,
                           input logic [31:0] addr, input logic [31:0] data,
                           input string name);
    bit          is_err;
    int          lat_exp, k, rd0, wr0, width;
    bit          got;
    logic [31:0] exp_v;
    is_err  = (rd && wr) || (addr[31:8] != 24'd0);
    lat_exp = is_err ? 1 : cyc_of(d) + 3;
    if (!is_err && wr) exp_mem[d][addr[7:0]] = data;
    if (!is_err && rd) exp_rd[d] = exp_mem[d][addr[7:0]];
    exp_q.push_back(exp_rd[d]);
    rd0 = rd_pulses[d];
    wr0 = wr_pulses[d];
    @(negedge clock);
    req_rd[d] = rd; req_wr[d] = wr; mar[d] = addr; mdr_out[d] = data;
    @(posedge clock);
    @(negedge clock);
    req_rd[d] = 1'b0; req_wr[d] = 1'b0;
    mar[d] = $urandom; mdr_out[d] = $urandom;
    total++;
    if (busy[d] !== 1'b1) begin
      bad++; $display("FAIL %s busy: got %0b want 1", name, busy[d]);
    end
    k = 1; got = 0;
    while (k <= 20 && !got) begin
      if (done[d] === 1'b1) got = 1;
      else begin @(negedge clock); k++; end
    end
    exp_v = exp_q.pop_front();
    total++;
    if (!got) begin
      bad++; $display("FAIL %s timeout: no done within 20 cycles", name);
      return;
    end
    if (k != lat_exp) begin
      bad++; $display("FAIL %s latency: got %0d want %0d", name, k, lat_exp);
    end
    total++;
    if (err[d] !== is_err) begin
      bad++; $display("FAIL %s err: got %0b want %0b", name, err[d], is_err);
    end
    total++;
    if (rd_data[d] !== exp_v) begin
      bad++; $display("FAIL %s rd_data: got %h want %h", name, rd_data[d], exp_v);
    end
    total++;
    if ((rd_pulses[d] - rd0) != ((!is_err && rd) ? 1 : 0)) begin
      bad++; $display("FAIL %s rd_pulses: got %0d", name, rd_pulses[d] - rd0);
    end
    total++;
    if ((wr_pulses[d] - wr0) != ((!is_err && wr) ? 1 : 0)) begin
      bad++; $display("FAIL %s wr_pulses: got %0d", name, wr_pulses[d] - wr0);
    end
    if (!is_err) begin
      width = rd ? rd_width[d] : wr_width[d];
      total++;
      if (width != cyc_of(d)) begin
        bad++; $display("FAIL %s strobe_width: got %0d want %0d", name, width, cyc_of(d));
      end
      total++;
      if (strobe_addr[d] !== addr[7:0]) begin
        bad++; $display("FAIL %s strobe_addr: got %h want %h", name, strobe_addr[d], addr[7:0]);
      end
    end
  endtask

  task automatic test_reset();
    clear = 1'b1;
    for (int d = 0; d < 2; d++) begin
      req_rd[d] = 1'b0; req_wr[d] = 1'b0; mar[d] = '0; mdr_out[d] = '0;
      exp_rd[d] = '0;
      for (int a = 0; a < 256; a++) exp_mem[d][a] = init_pat(d, a);
    end
    repeat (3) @(negedge clock);
    for (int d = 0; d < 2; d++) begin
      total++;
      if ({busy[d], done[d], err[d], ram_read[d], ram_write[d]} !== 5'b0) begin
        bad++; $display("FAIL reset_flags[%0d]: got %b want 00000", d,
                        {busy[d], done[d], err[d], ram_read[d], ram_write[d]});
      end
      total++;
      if (rd_data[d] !== 32'd0 || ram_din[d] !== 32'd0 || ram_addr[d] !== 8'd0) begin
        bad++; $display("FAIL reset_data[%0d]: rd=%h din=%h addr=%h want zeros",
                        d, rd_data[d], ram_din[d], ram_addr[d]);
      end
      total++;
      if (dbg[d] !== 3'd0) begin
        bad++; $display("FAIL reset_state[%0d]: got %0d want 0", d, dbg[d]);
      end
    end
    clear = 1'b0;
  endtask

  task automatic test_write_read();
    do_access(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, "write_0x10");
    do_access(0, 1'b1, 1'b0, 32'h10, $urandom, "read_0x10");
    total++;
    if (rd_data[0] !== 32'hDEADBEEF) begin
      bad++; $display("FAIL read_back: got %h want deadbeef", rd_data[0]);
    end
  endtask

  task automatic test_errors();
    do_access(0, 1'b1, 1'b0, 32'h100, $urandom, "bad_addr_0x100");
    do_access(0, 1'b1, 1'b1, 32'h20, $urandom, "conflict");
    do_access(1, 1'b0, 1'b1, 32'h8000_0004, $urandom, "bad_addr_hi_wr");
  endtask

  task automatic test_strobe3();
    do_access(1, 1'b1, 1'b0, 32'hFF, $urandom, "read_0xff_init");
    do_access(1, 1'b0, 1'b1, 32'hFF, $urandom, "write_0xff");
    do_access(1, 1'b1, 1'b0, 32'hFF, $urandom, "read_0xff");
  endtask

  task automatic test_clear_mid();
    logic [31:0] data;
    int          seen_done;
    data = $urandom;
    @(negedge clock);
    req_wr[1] = 1'b1; mar[1] = 32'h20; mdr_out[1] = data;
    @(posedge clock);
    @(negedge clock);
    req_wr[1] = 1'b0;
    @(negedge clock);
    total++;
    if (ram_write[1] !== 1'b1) begin
      bad++; $display("FAIL clear_pre_strobe: got %0b want 1", ram_write[1]);
    end
    #2 clear = 1'b1;
    #1;
    total++;
    if ({ram_write[1], busy[1], done[1], err[1]} !== 4'b0) begin
      bad++; $display("FAIL clear_async: got %b want 0000",
                      {ram_write[1], busy[1], done[1], err[1]});
    end
    exp_mem[1][8'h20] = data;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    @(negedge clock);
    clear = 1'b0;
    seen_done = 0;
    repeat (8) begin
      @(negedge clock);
      if (done[1] === 1'b1) seen_done++;
    end
    total++;
    if (seen_done != 0) begin
      bad++; $display("FAIL clear_no_done: got %0d done pulses want 0", seen_done);
    end
    total++;
    if (rd_data[1] !== 32'd0) begin
      bad++; $display("FAIL clear_rd_data: got %h want 0", rd_data[1]);
    end
    do_access(1, 1'b1, 1'b0, 32'h33, $urandom, "read_after_clear");
  endtask

  task automatic test_held_request();
    int dones, first_k, second_k, rd0;
    rd0 = rd_pulses[0];
    dones = 0; first_k = 0; second_k = 0;
    exp_rd[0] = exp_mem[0][8'h44];
    @(negedge clock);
    req_rd[0] = 1'b1; mar[0] = 32'h44;
    @(posedge clock);
    for (int k = 1; k <= 14; k++) begin
      @(negedge clock);
      if (done[0] === 1'b1) begin
        dones++;
        if (dones == 1) first_k = k;
        if (dones == 2) begin second_k = k; req_rd[0] = 1'b0; end
      end
    end
    req_rd[0] = 1'b0;
    total++;
    if (dones != 2 || first_k != 4 || second_k != 9) begin
      bad++; $display("FAIL held_done: got n=%0d at %0d,%0d want n=2 at 4,9",
                      dones, first_k, second_k);
    end
    total++;
    if ((rd_pulses[0] - rd0) != 2) begin
      bad++; $display("FAIL held_pulses: got %0d want 2", rd_pulses[0] - rd0);
    end
    total++;
    if (rd_data[0] !== exp_rd[0]) begin
      bad++; $display("FAIL held_rd_data: got %h want %h", rd_data[0], exp_rd[0]);
    end
  endtask

  task automatic test_back_to_back();
    int          d, kind;
    logic [31:0] addr;
    for (int i = 0; i < 40; i++) begin
      d    = $urandom_range(0, 1);
      kind = $urandom_range(0, 9);
      addr = (kind[0]) ? 32'($urandom_range(0, 15)) : 32'($urandom_range(240, 255));
      case (kind)
        0: do_access(d, 1'b1, 1'b1, addr, $urandom, "rand_conflict");
        1: begin
          addr = $urandom;
          if (addr[31:8] == 24'd0) addr[31] = 1'b1;
          do_access(d, kind[2], ~kind[2], addr, $urandom, "rand_bad_addr");
        end
        2, 3, 4, 5: do_access(d, 1'b0, 1'b1, addr, $urandom, "rand_write");
        default:    do_access(d, 1'b1, 1'b0, addr, $urandom, "rand_read");
      endcase
    end
  endtask

  task automatic test_no_overlap();
    for (int d = 0; d < 2; d++) begin
      total++;
      if (overlaps[d] != 0) begin
        bad++; $display("FAIL overlap[%0d]: got %0d cycles want 0", d, overlaps[d]);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_write_read();
    test_errors();
    test_strobe3();
    test_clear_mid();
    test_held_request();
    test_back_to_back();
    test_no_overlap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
